// File: rtl/reg_bank_wr.sv
// reg_bank_wr: MIPS general-purpose register bank, 32 x DATA_W bits.
// One write port, two combinational read ports. Register 0 reads as zero
// and has no storage; register 29 ($sp) resets to SP_RESET.
// Optional feature: define REG_BANK_BYPASS_EN to forward write data to a
// read port that addresses the register being written in the same cycle.
module reg_bank_wr #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'd227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_wr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [4:0]        last_wr_addr
);

  localparam logic [4:0] SP_IDX = 5'd29;

  // Register 0 is hardwired, so storage starts at index 1.
  logic [DATA_W-1:0] regs [1:31];

  logic wr_commit;
  assign wr_commit = reg_wr && (wr_addr != 5'd0);

  // Register array and last-write tracker: async reset, commit on rising edge.
  // NOTE: the array is reset element by element because $sp has a defined
  // non-zero reset value and software relies on every register starting known;
  // this forces flops rather than a RAM macro, which is acceptable at 31 words.
  // NOTE: sequential state uses non-blocking assignments only, so every read in
  // this edge sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (5'(i) == SP_IDX) ? SP_RESET : '0;
      end
      last_wr_addr <= 5'd0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
      last_wr_addr  <= wr_addr;
    end
  end

  // Read ports: index 0 returns zero, otherwise the stored value, optionally
  // overridden by same-cycle write data when bypass is built in.
  // NOTE: both outputs get a default first so no path through the block can
  // leave them unassigned and infer a latch.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != 5'd0) rd_data_a = regs[rd_addr_a];
    if (rd_addr_b != 5'd0) rd_data_b = regs[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    // Forwarding is suppressed while in reset so outputs show reset contents.
    if (reset_n && wr_commit && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (reset_n && wr_commit && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`else
    // Without bypass a write becomes visible only after it commits.
`endif
  end

endmodule
